// File: rtl/stream_demultiplexer_pkg.sv
// Shared constants and types for the stream demultiplexer: channel count,
// default word width and the per-channel buffer state encoding.
package stream_demultiplexer_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int NUM_CHANNELS  = 4;
    localparam int ADDR_W        = $clog2(NUM_CHANNELS);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    // Turns a channel address into the one-hot load vector for the slots.
    function automatic logic [NUM_CHANNELS-1:0] channel_onehot(input logic [ADDR_W-1:0] addr);
        return NUM_CHANNELS'(1) << addr;
    endfunction

endpackage

// File: rtl/demux_channel_slot.sv
// One-entry registered output buffer for a single demultiplexer channel,
// with a two-state EMPTY/FULL controller and valid/ready handshake.
module demux_channel_slot
    import stream_demultiplexer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    slot_state_t      r_state;
    slot_state_t      w_next_state;
    logic [WIDTH-1:0] r_data;
    logic             w_capture;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A load while FULL only arrives when the consumer is draining, so it is a refill with no bubble.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        case (r_state)
            EMPTY: begin
                if (load) begin
                    w_next_state = FULL;
                    w_capture    = 1'b1;
                end
            end
            FULL: begin
                if (load) begin
                    w_capture = 1'b1;
                end else if (out_ready) begin
                    w_next_state = EMPTY;
                end
            end
            default: w_next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (w_capture) begin
            r_data <= load_data;
        end
    end

    assign out_data  = r_data;
    assign out_valid = (r_state == FULL);

endmodule

// File: rtl/stream_demultiplexer.sv
// Routes one tagged word stream onto four independently buffered output
// channels selected by {address1, address0}.
module stream_demultiplexer
    import stream_demultiplexer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             address0,
    input  logic             address1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic [WIDTH-1:0] out1_data,
    output logic [WIDTH-1:0] out2_data,
    output logic [WIDTH-1:0] out3_data,
    output logic             out0_valid,
    output logic             out1_valid,
    output logic             out2_valid,
    output logic             out3_valid,
    input  logic             out0_ready,
    input  logic             out1_ready,
    input  logic             out2_ready,
    input  logic             out3_ready
);

    logic [ADDR_W-1:0]       w_addr;
    logic [NUM_CHANNELS-1:0] w_out_valid;
    logic [NUM_CHANNELS-1:0] w_out_ready;
    logic [NUM_CHANNELS-1:0] w_load;
    logic [WIDTH-1:0]        w_out_data [NUM_CHANNELS];
    logic                    w_accept;

    assign w_addr      = {address1, address0};
    assign w_out_ready = {out3_ready, out2_ready, out1_ready, out0_ready};

    // Only the addressed slot gates the input, so a stalled channel never blocks the others.
    assign in_ready = ~reset & (~w_out_valid[w_addr] | w_out_ready[w_addr]);
    assign w_accept = in_valid & in_ready;
    assign w_load   = w_accept ? channel_onehot(w_addr) : '0;

    for (genvar n = 0; n < NUM_CHANNELS; n++) begin : g_slot
        demux_channel_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load     (w_load[n]),
            .load_data(in_data),
            .out_ready(w_out_ready[n]),
            .out_data (w_out_data[n]),
            .out_valid(w_out_valid[n])
        );
    end

    assign out0_data  = w_out_data[0];
    assign out1_data  = w_out_data[1];
    assign out2_data  = w_out_data[2];
    assign out3_data  = w_out_data[3];
    assign out0_valid = w_out_valid[0];
    assign out1_valid = w_out_valid[1];
    assign out2_valid = w_out_valid[2];
    assign out3_valid = w_out_valid[3];

endmodule
